countdown_core: RTL and testbench

//  Upstream stage of the 8-digit seven-segment display controller: turns the raw start/pause push-button

---
 rtl/countdown_core.sv | 149 ++++++++++++++
 tb/tb_countdown_core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_core.sv
// Countdown core: debounced start/pause button driving a 1 Hz BCD countdown
// from START_VAL to 0 with run/pause/done status for the display controller.
module countdown_core #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DEBOUNCE_CYC = 2_000_000,
    parameter int unsigned START_VAL    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       running,
    output logic       paused,
    output logic       done,
    output logic       sec_tick
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYC - 1);
    localparam logic [3:0]    START_TENS = 4'(START_VAL / 10);
    localparam logic [3:0]    START_ONES = 4'(START_VAL % 10);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          deb;
    logic          deb_q;
    logic          press;
    logic [DW-1:0] db_cnt;
    logic [PW-1:0] presc;
    logic [3:0]    tens;
    logic [3:0]    ones;
    logic [3:0]    dec_tens;
    logic [3:0]    dec_ones;
    logic          last_step;
    logic          step;

    // Button conditioning: synchroniser, debounce, registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            press  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            if (sync2 != deb) begin
                if (db_cnt == DB_MAX) begin
                    deb    <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        dec_tens = tens;
        dec_ones = ones - 4'd1;
        if (ones == 4'd0) begin
            dec_tens = tens - 4'd1;
            dec_ones = 4'd9;
        end
    end

    assign last_step = (tens == 4'd0) && (ones == 4'd1);
    assign step      = (state == RUN) && (presc == PRESC_MAX);

    // A terminal step takes priority over a simultaneous press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tens     <= START_TENS;
            ones     <= START_ONES;
            presc    <= '0;
            done     <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            done     <= 1'b0;
            sec_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tens <= START_TENS;
                    ones <= START_ONES;
                    if (press) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (step) begin
                        presc    <= '0;
                        tens     <= dec_tens;
                        ones     <= dec_ones;
                        sec_tick <= 1'b1;
                        if (last_step) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (press) begin
                            state <= PAUSE;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                        if (press) begin
                            state <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    if (press) begin
                        state <= RUN;
                    end
                end
                DONE: begin
                    if (press) begin
                        state <= IDLE;
                        tens  <= START_TENS;
                        ones  <= START_ONES;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_tens = tens;
    assign cnt_ones = ones;
    assign running  = (state == RUN);
    assign paused   = (state == PAUSE);

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core: a time-based reference model predicts every
// output change; a monitor pops and compares whenever the DUT outputs change.
module tb_countdown_core;

    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int START  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic [3:0] cnt_tens;
    logic [3:0] cnt_ones;
    logic       running;
    logic       paused;
    logic       done;
    logic       sec_tick;

    countdown_core #(
        .CLK_HZ(CLK_HZ),
        .DEBOUNCE_CYC(DEB),
        .START_VAL(START)
    ) dut (
        .clk(clk),
        .rst(rst),
        .button(button),
        .cnt_tens(cnt_tens),
        .cnt_ones(cnt_ones),
        .running(running),
        .paused(paused),
        .done(done),
        .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [11:0] v;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   edge_n     = 0;

    // Reference model state: mode 0 idle, 1 run, 2 pause, 3 done; run_cyc = cycles spent running.
    int          m_state = 0;
    int          run_cyc = 0;
    int          last_b  = 0;
    int          run_len = 0;
    int          deb_m   = 0;
    int          press_q[$];
    logic [11:0] m_prev;
    bit          m_first = 1'b1;

    function automatic logic [11:0] pack(input int cnt, input bit r, input bit p,
                                         input bit d, input bit t);
        return {4'(cnt / 10), 4'(cnt % 10), r, p, d, t};
    endfunction

    always @(posedge clk) begin
        bit          pr;
        bit          tick;
        bit          dn;
        int          b;
        int          cnt;
        logic [11:0] v;
        exp_t        e;
        edge_n++;
        pr   = 1'b0;
        tick = 1'b0;
        dn   = 1'b0;
        b    = (button === 1'b1) ? 1 : 0;
        if (b == last_b) run_len++;
        else begin
            run_len = 1;
            last_b  = b;
        end
        if (rst === 1'b1) begin
            m_state = 0;
            run_cyc = 0;
            deb_m   = 0;
            press_q.delete();
        end else begin
            // A level held for DEB samples is accepted; a press acts 4 edges after its DEB-th sample.
            if (b != deb_m && run_len == DEB) begin
                deb_m = b;
                if (b == 1) press_q.push_back(edge_n + 4);
            end
            if (press_q.size() > 0 && press_q[0] == edge_n) begin
                pr = 1'b1;
                void'(press_q.pop_front());
            end
            case (m_state)
                0: if (pr) begin
                    m_state = 1;
                    run_cyc = 0;
                end
                1: begin
                    run_cyc++;
                    if (run_cyc % CLK_HZ == 0) begin
                        tick = 1'b1;
                        if (START - run_cyc / CLK_HZ == 0) begin
                            m_state = 3;
                            dn      = 1'b1;
                        end else if (pr) m_state = 2;
                    end else if (pr) m_state = 2;
                end
                2: if (pr) m_state = 1;
                default: if (pr) m_state = 0;
            endcase
        end
        cnt = (m_state == 0) ? START : START - run_cyc / CLK_HZ;
        v   = pack(cnt, m_state == 1, m_state == 2, dn, tick);
        if (m_first || v != m_prev) begin
            e.cyc = edge_n;
            e.v   = v;
            sb.push_back(e);
        end
        m_prev  = v;
        m_first = 1'b0;
    end

    logic [11:0] o_prev;
    bit          o_first = 1'b1;

    always @(negedge clk) begin
        logic [11:0] o;
        exp_t        e;
        o = {cnt_tens, cnt_ones, running, paused, done, sec_tick};
        if (edge_n > 0) begin
            while (sb.size() > 0 && sb[0].cyc < edge_n) begin
                e = sb.pop_front();
                compared++;
                mismatched++;
                $display("FAIL missing_change: DUT outputs %h, required %h at edge %0d",
                         o, e.v, e.cyc);
            end
            if (o_first || o !== o_prev) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_change: DUT outputs %h at edge %0d, no change required",
                             o, edge_n);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != edge_n || e.v !== o) begin
                        mismatched++;
                        $display("FAIL output_change: got %h at edge %0d, required %h at edge %0d",
                                 o, edge_n, e.v, e.cyc);
                    end
                end
            end
            o_prev  = o;
            o_first = 1'b0;
        end
    end

    task automatic hold(input logic lvl, input int n);
        button = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input int target);
        int k;
        k = 0;
        while (!(m_state == 1 && run_cyc == target) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            compared++;
            mismatched++;
            $display("FAIL wait_run: run_cyc %0d, required %0d within budget", run_cyc, target);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (m_state != 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            compared++;
            mismatched++;
            $display("FAIL wait_done: model state %0d, required 3 within budget", m_state);
        end
    endtask

    initial begin
        rst    = 1'b1;
        button = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 10);
        // Start and count all the way to zero.
        hold(1'b1, 20);
        hold(1'b0, 10);
        wait_done();
        hold(1'b0, 20);
        // DONE -> IDLE, glitches in IDLE, stable 4-cycle press, glitches in RUN.
        hold(1'b1, 6);
        hold(1'b0, 10);
        for (int g = 1; g <= 3; g++) begin
            hold(1'b1, g);
            hold(1'b0, 6);
        end
        hold(1'b1, 4);
        hold(1'b0, 6);
        for (int g = 1; g <= 3; g++) begin
            hold(1'b1, g);
            hold(1'b0, 5);
        end
        // Pause lands at count 07, prescaler 6; hold 50 cycles, then resume.
        wait_run(28);
        hold(1'b1, 6);
        hold(1'b0, 44);
        hold(1'b1, 6);
        hold(1'b0, 6);
        // Press coincident with the 05->04 step, then with the final step.
        wait_run(52);
        hold(1'b1, 6);
        hold(1'b0, 6);
        hold(1'b1, 6);
        hold(1'b0, 6);
        wait_run(92);
        hold(1'b1, 6);
        hold(1'b0, 20);
        // DONE -> IDLE, start, reset mid-run at count 03.
        hold(1'b1, 6);
        hold(1'b0, 10);
        hold(1'b1, 6);
        hold(1'b0, 6);
        wait_run(72);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 10);
        // Random button activity with occasional resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                hold(1'b0, DEB + 4);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        hold(1'b0, 20);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL leftover_change: required %h at edge %0d never observed", e.v, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
